// File: rtl/pipe_pkg.sv
// Shared definitions for the handshaked pipeline stage register.
// Stage FSM encoding plus ID/EXE control and data field layout.
// No logic; constants and types only.
package pipe_pkg;

  // Occupancy of a stage: no entry, main only, main plus skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_e;

  // ID/EXE control bundle bit offsets.
  localparam int CTRL_ALUOP_LSB   = 0;   // AluOp[3:0]
  localparam int CTRL_ALUOP_W     = 4;
  localparam int CTRL_REGDST_LSB  = 4;   // RegDst[5:4]
  localparam int CTRL_REGDST_W    = 2;
  localparam int CTRL_ALUSRC_BIT  = 6;
  localparam int CTRL_ALUSRC1_BIT = 7;
  localparam int CTRL_MEMWR_BIT   = 8;
  localparam int CTRL_MEMRD_BIT   = 9;
  localparam int CTRL_MEM2REG_BIT = 10;
  localparam int CTRL_DATAC_BIT   = 11;
  localparam int ID_EXE_CTRL_W    = 12;

  // ID/EXE data bundle default field widths.
  localparam int IMM_W    = 32;
  localparam int RDATA_W  = 32;
  localparam int REG_W    = 5;
  localparam int SHAMT_W  = 5;
  localparam int PC_W     = 32;

  // ID/EXE data bundle field offsets, LSB first: PC+4, shamt, rd, rt, rdata2, rdata1, imm32.
  localparam int DATA_PC4_LSB    = 0;
  localparam int DATA_SHAMT_LSB  = DATA_PC4_LSB + PC_W;
  localparam int DATA_RD_LSB     = DATA_SHAMT_LSB + SHAMT_W;
  localparam int DATA_RT_LSB     = DATA_RD_LSB + REG_W;
  localparam int DATA_RDATA2_LSB = DATA_RT_LSB + REG_W;
  localparam int DATA_RDATA1_LSB = DATA_RDATA2_LSB + RDATA_W;
  localparam int DATA_IMM_LSB    = DATA_RDATA1_LSB + RDATA_W;
  localparam int ID_EXE_DATA_W   = DATA_IMM_LSB + IMM_W;  // 143

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter for pipeline performance debug.
// Count visible one cycle after the inc cycle.
// No backpressure; holds at all-ones once saturated.
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Advance by one unless already at the maximum value.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with optional 2-entry skid buffer and flush.
// 1 cycle from accept to out_*; 1 entry/cycle while out_ready is high.
// SKID=1: registered in_ready, absorbs one entry after a stall; SKID=0: combinational in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = ID_EXE_CTRL_W,
  parameter int DATA_W = ID_EXE_DATA_W,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  pipe_state_e       state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              in_ready_q;
  logic              accept;
  logic              drain;

  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = (SKID != 0) ? in_ready_q : (out_ready | ~out_valid);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  // A bubble presents all-zero controls so it behaves as a NOP downstream.
  assign out_ctrl  = out_valid ? main_ctrl_q : '0;
  assign out_data  = main_data_q;

  // Next-state and register loads; flush overrides any same-cycle handshake.
  // With SKID=0, in_ready guarantees accept implies drain once full, so ST_TWO is never entered.
  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      state_d     = ST_EMPTY;
      main_ctrl_d = '0;
      main_data_d = '0;
      skid_ctrl_d = '0;
      skid_data_d = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d     = ST_ONE;
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (accept) begin
            state_d     = ST_TWO;
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
          end else if (drain) begin
            state_d     = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (drain) begin
            state_d     = ST_ONE;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // State and payload registers; in_ready is precomputed from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      in_ready_q  <= (state_d != ST_TWO);
    end
  end

  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (out_valid & ~out_ready),
    .cnt_o (stall_cnt)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (~out_valid),
    .cnt_o (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: SKID=1 main instance, CNT_W=4 saturation instance
// sharing its stimulus, and a separately driven SKID=0 instance.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_pipe_stage_reg;

  localparam int CW = 12;
  localparam int DW = 143;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for SKID=1 instances.
  logic          flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, out_valid;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [15:0]   stall_cnt, bubble_cnt;

  logic          sat_in_ready, sat_out_valid;
  logic [CW-1:0] sat_out_ctrl;
  logic [DW-1:0] sat_out_data;
  logic [3:0]    sat_stall_cnt, sat_bubble_cnt;

  // SKID=0 instance signals.
  logic          s0_flush = 1'b0, s0_in_valid = 1'b0, s0_out_ready = 1'b0;
  logic [CW-1:0] s0_in_ctrl = '0;
  logic [DW-1:0] s0_in_data = '0;
  logic          s0_in_ready, s0_out_valid;
  logic [CW-1:0] s0_out_ctrl;
  logic [DW-1:0] s0_out_data;
  logic [15:0]   s0_stall_cnt, s0_bubble_cnt;

  int tests = 0;
  int fails = 0;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(sat_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(sat_out_valid), .out_ready(out_ready),
    .out_ctrl(sat_out_ctrl), .out_data(sat_out_data), .stall_cnt(sat_stall_cnt),
    .bubble_cnt(sat_bubble_cnt)
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CNT_W(16)) u_s0 (
    .clk(clk), .rst_n(rst_n), .flush(s0_flush), .in_valid(s0_in_valid), .in_ready(s0_in_ready),
    .in_ctrl(s0_in_ctrl), .in_data(s0_in_data), .out_valid(s0_out_valid), .out_ready(s0_out_ready),
    .out_ctrl(s0_out_ctrl), .out_data(s0_out_data), .stall_cnt(s0_stall_cnt),
    .bubble_cnt(s0_bubble_cnt)
  );

  // Data payload derived from the control tag so both bundles are checked.
  function automatic logic [DW-1:0] mk_data(input logic [CW-1:0] c);
    return {c, 119'h5A5A_1234_ABCD_0F0F_7777, c ^ 12'hFFF};
  endfunction

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    // ---------------- reset ----------------
    tick(); tick();
    chk("rst_out_valid", 160'(out_valid), 160'(1'b0));
    chk("rst_out_ctrl",  160'(out_ctrl),  160'(0));
    chk("rst_out_data",  160'(out_data),  160'(0));
    chk("rst_in_ready",  160'(in_ready),  160'(1'b1));
    chk("rst_stall",     160'(stall_cnt), 160'(0));
    chk("rst_bubble",    160'(bubble_cnt),160'(0));
    chk("rst_s0_in_ready", 160'(s0_in_ready), 160'(1'b1));
    rst_n = 1'b1;

    // ---------------- idle: bubble counting and saturation ----------------
    for (int i = 0; i < 20; i++) tick();
    chk("idle_bubble20", 160'(bubble_cnt),     160'(20));
    chk("sat_bubble15",  160'(sat_bubble_cnt), 160'(15));

    // ---------------- stream 8 entries, out_ready=1 ----------------
    out_ready = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        chk("stream_valid", 160'(out_valid), 160'(1'b1));
        chk("stream_ctrl",  160'(out_ctrl),  160'(i));
        chk("stream_data",  160'(out_data),  160'(mk_data(CW'(i))));
        chk("stream_rdy",   160'(in_ready),  160'(1'b1));
      end
      if (i < 8) begin
        in_valid = 1'b1;
        in_ctrl  = CW'(i + 1);
        in_data  = mk_data(CW'(i + 1));
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    chk("stream_drained", 160'(out_valid), 160'(1'b0));
    chk("stream_ctrl0",   160'(out_ctrl),  160'(0));
    chk("stream_stall0",  160'(stall_cnt), 160'(0));

    // ---------------- back-pressure, SKID=1 ----------------
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 12'h0A1; in_data = mk_data(12'h0A1);
    tick();
    chk("bp_a_valid", 160'(out_valid), 160'(1'b1));
    chk("bp_a_ctrl",  160'(out_ctrl),  160'(12'h0A1));
    chk("bp_a_rdy",   160'(in_ready),  160'(1'b1));
    in_ctrl = 12'h0B2; in_data = mk_data(12'h0B2);
    tick();
    chk("bp_two_rdy",  160'(in_ready),  160'(1'b0));
    chk("bp_two_ctrl", 160'(out_ctrl),  160'(12'h0A1));
    chk("bp_stall1",   160'(stall_cnt), 160'(1));
    in_valid = 1'b0;
    tick();
    chk("bp_hold_rdy",  160'(in_ready), 160'(1'b0));
    chk("bp_hold_ctrl", 160'(out_ctrl), 160'(12'h0A1));
    tick();
    chk("bp_stall3",    160'(stall_cnt), 160'(3));
    chk("bp_hold_ctrl2",160'(out_ctrl),  160'(12'h0A1));
    chk("bp_hold_data", 160'(out_data),  160'(mk_data(12'h0A1)));
    out_ready = 1'b1;
    tick();
    chk("bp_b_valid", 160'(out_valid), 160'(1'b1));
    chk("bp_b_ctrl",  160'(out_ctrl),  160'(12'h0B2));
    chk("bp_b_data",  160'(out_data),  160'(mk_data(12'h0B2)));
    chk("bp_b_rdy",   160'(in_ready),  160'(1'b1));
    chk("bp_b_stall", 160'(stall_cnt), 160'(3));
    tick();
    chk("bp_empty_valid", 160'(out_valid), 160'(1'b0));
    chk("bp_empty_ctrl",  160'(out_ctrl),  160'(0));
    chk("bp_last_data",   160'(out_data),  160'(mk_data(12'h0B2)));

    // ---------------- flush while TWO ----------------
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 12'h0D1; in_data = mk_data(12'h0D1);
    tick();
    in_ctrl = 12'h0D2; in_data = mk_data(12'h0D2);
    tick();
    chk("fl_two_rdy",  160'(in_ready),  160'(1'b0));
    chk("fl_two_ctrl", 160'(out_ctrl),  160'(12'h0D1));
    chk("fl_stall4",   160'(stall_cnt), 160'(4));
    in_ctrl = 12'h0D3; in_data = mk_data(12'h0D3);
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid0", 160'(out_valid), 160'(1'b0));
    chk("fl_ctrl0",  160'(out_ctrl),  160'(0));
    chk("fl_data0",  160'(out_data),  160'(0));
    chk("fl_rdy1",   160'(in_ready),  160'(1'b1));
    chk("fl_stall_kept", 160'(stall_cnt), 160'(4));
    tick();
    chk("fl_no_c", 160'(out_valid), 160'(1'b0));
    tick();
    chk("fl_no_c2", 160'(out_valid), 160'(1'b0));

    // ---------------- SKID=0 mode ----------------
    s0_out_ready = 1'b0;
    s0_in_valid = 1'b1; s0_in_ctrl = 12'h0E1; s0_in_data = mk_data(12'h0E1);
    #1;
    chk("s0_empty_rdy", 160'(s0_in_ready), 160'(1'b1));
    tick();
    s0_in_valid = 1'b0;
    #1;
    chk("s0_x_valid",  160'(s0_out_valid), 160'(1'b1));
    chk("s0_x_ctrl",   160'(s0_out_ctrl),  160'(12'h0E1));
    chk("s0_stall_rdy",160'(s0_in_ready),  160'(1'b0));
    tick();
    chk("s0_stall1",   160'(s0_stall_cnt), 160'(1));
    chk("s0_x_hold",   160'(s0_out_ctrl),  160'(12'h0E1));
    s0_out_ready = 1'b1;
    #1;
    chk("s0_comb_rdy", 160'(s0_in_ready), 160'(1'b1));
    s0_in_valid = 1'b1; s0_in_ctrl = 12'h0E2; s0_in_data = mk_data(12'h0E2);
    tick();
    chk("s0_y_ctrl", 160'(s0_out_ctrl), 160'(12'h0E2));
    chk("s0_y_data", 160'(s0_out_data), 160'(mk_data(12'h0E2)));
    chk("s0_y_rdy",  160'(s0_in_ready), 160'(1'b1));
    s0_in_ctrl = 12'h0E3; s0_in_data = mk_data(12'h0E3);
    tick();
    chk("s0_z_ctrl",  160'(s0_out_ctrl),  160'(12'h0E3));
    chk("s0_z_valid", 160'(s0_out_valid), 160'(1'b1));
    s0_in_valid = 1'b0;
    tick();
    chk("s0_drained",  160'(s0_out_valid), 160'(1'b0));
    chk("s0_ctrl0",    160'(s0_out_ctrl),  160'(0));
    chk("s0_stall_end",160'(s0_stall_cnt), 160'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
